// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
  localparam int DATA_W_DEF = 20;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first unmasked request at or after start wins.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  exclude,
  output logic          valid,
  output logic [IW-1:0] index
);
  logic [N-1:0] m;
  assign m = req & ~exclude;
  // Scan farthest-first so the candidate closest to start overwrites the rest.
  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(start) + k) % N;
      if (m[j]) begin
        valid = 1'b1;
        index = IW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-bounded sharing of one FIFO write port among N_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = cnt_width(MAX_BURST);
  state_t state, state_n;
  logic [N_REQ-1:0] gnt_n, excl;
  logic [OW-1:0] owner_n, ptr, ptr_n, nxt_idx, start, pick_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic beat, rel, load, pick_valid;
  assign nxt_idx = owner == OW'(N_REQ - 1) ? '0 : owner + 1'b1;
  assign beat = state == BUSY && gnt[owner] && req[owner] && !fifo_full;
  assign rel = state == BUSY && ((beat && cnt == CW'(MAX_BURST - 1)) || !req[owner]);
  assign load = state == IDLE || rel;
  assign start = state == IDLE ? ptr : nxt_idx;
  // A holder that dropped its request must not win the handover pick.
  assign excl = state == BUSY && !req[owner] ? N_REQ'(1) << owner : '0;
  rr_pick #(.N(N_REQ)) u_pick (
    .req(req),
    .start(start),
    .exclude(excl),
    .valid(pick_valid),
    .index(pick_idx)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n = load ? (pick_valid ? BUSY : IDLE) : state;
    gnt_n   = load ? (pick_valid ? N_REQ'(1) << pick_idx : '0) : gnt;
    owner_n = load ? (pick_valid ? pick_idx : '0) : owner;
    ptr_n   = rel ? nxt_idx : ptr;
    cnt_n   = load ? '0 : cnt + CW'(beat);
  end
  always_comb begin
    busy         = state == BUSY;
    fifo_write   = beat;
    fifo_data_in = busy ? req_data[int'(owner) * DATA_W +: DATA_W] : '0;
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table, directed corner sequences and a randomized run against a queue-free reference model.
module tb_fifo_write_arbiter;
  logic clk, reset, fifo_full, fifo_write, busy;
  logic [3:0] req, gnt;
  logic [79:0] req_data;
  logic [19:0] fifo_data_in;
  logic [1:0] owner;
  logic [19:0] words [4];
  int tests = 0, fails = 0;

  assign req_data = {words[3], words[2], words[1], words[0]};

  fifo_write_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_data_in(fifo_data_in),
    .busy(busy), .owner(owner)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [3:0] rq; logic full;
    logic [3:0] g; logic wr; logic bz; logic [1:0] own; logic [19:0] d;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] rq, logic full, logic [3:0] g,
                              logic wr, logic bz, logic [1:0] own, logic [19:0] d);
    vec_t r;
    r = '{rst, rq, full, g, wr, bz, own, d};
    return r;
  endfunction

  function automatic int pick(logic [3:0] r, int s);
    for (int k = 0; k < 4; k++) if (r[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    nxt;
    reset = 1; req = 0; fifo_full = 0;
    nxt;
    reset = 0;
  endtask

  int m_own, m_ptr, m_cnt, adv;
  logic e_bz, e_wr;
  logic [3:0] e_g;
  logic [19:0] e_d;

  initial begin
    reset = 1; req = 0; fifo_full = 0;
    for (int i = 0; i < 4; i++) words[i] = 20'h11111 * 20'(i + 1);
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 20'h0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0, 20'h0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 20'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0101, 0, 4'b0001, 1, 1, 0, 20'h11111));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0101, 0, 4'b0100, 1, 1, 2, 20'h33333));
    tbl.push_back(mk(0, 4'b0101, 0, 4'b0001, 1, 1, 0, 20'h11111));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0001, 0, 1, 0, 20'h11111));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0, 0, 20'h0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0010, 1, 1, 1, 20'h22222));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b1010, 0, 4'b0010, 1, 1, 1, 20'h22222));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b1010, 0, 4'b1000, 1, 1, 3, 20'h44444));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0010, 1, 1, 1, 20'h22222));
    foreach (tbl[i]) begin
      nxt;
      reset = tbl[i].rst; req = tbl[i].rq; fifo_full = tbl[i].full;
      smp;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_write", i), 32'(fifo_write), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].own));
      chk($sformatf("tbl%0d_data", i), 32'(fifo_data_in), 32'(tbl[i].d));
    end

    // Producer 1 alone: three words, then drop request.
    do_reset;
    req = 4'b0010; words[1] = 20'h00001;
    smp; chk("solo_idle_gnt", 32'(gnt), 0);
    nxt; smp;
    chk("solo_gnt", 32'(gnt), 32'b0010);
    chk("solo_w1", 32'(fifo_write), 1); chk("solo_d1", 32'(fifo_data_in), 1);
    nxt; words[1] = 20'h00003; smp;
    chk("solo_w2", 32'(fifo_write), 1); chk("solo_d2", 32'(fifo_data_in), 3);
    nxt; words[1] = 20'h00005; smp;
    chk("solo_w3", 32'(fifo_write), 1); chk("solo_d3", 32'(fifo_data_in), 5);
    nxt; req = 4'b0000; smp;
    chk("solo_dead_write", 32'(fifo_write), 0); chk("solo_dead_gnt", 32'(gnt), 32'b0010);
    nxt; smp;
    chk("solo_end_gnt", 32'(gnt), 0); chk("solo_end_busy", 32'(busy), 0);
    chk("solo_end_state", 32'(dut.state), 0);

    // Back-pressure during the second beat.
    do_reset;
    req = 4'b0001; words[0] = 20'hABCDE;
    smp;
    nxt; smp; chk("full_beat1", 32'(fifo_write), 1);
    for (int i = 0; i < 3; i++) begin
      nxt; fifo_full = 1; smp;
      chk("full_write", 32'(fifo_write), 0);
      chk("full_gnt", 32'(gnt), 32'b0001);
      chk("full_cnt", 32'(dut.cnt), 1);
    end
    for (int i = 0; i < 3; i++) begin
      nxt; fifo_full = 0; smp;
      chk("full_resume", 32'(fifo_write), 1);
    end
    nxt; smp;
    chk("full_repick_gnt", 32'(gnt), 32'b0001);
    chk("full_repick_cnt", 32'(dut.cnt), 0);

    // Asynchronous reset in the middle of producer 3's burst.
    do_reset;
    req = 4'b1000;
    smp;
    nxt; smp; chk("rst3_gnt", 32'(gnt), 32'b1000); chk("rst3_write", 32'(fifo_write), 1);
    nxt; #2; reset = 1; #1;
    chk("rst3_async_gnt", 32'(gnt), 0);
    chk("rst3_async_write", 32'(fifo_write), 0);
    chk("rst3_async_busy", 32'(busy), 0);
    nxt; reset = 0; req = 4'b1010; smp;
    chk("rst3_ptr", 32'(dut.ptr), 0);
    nxt; smp;
    chk("rst3_regnt", 32'(gnt), 32'b0010); chk("rst3_owner", 32'(owner), 1);

    // Randomized traffic against the reference model.
    do_reset;
    m_own = -1; m_ptr = 0; m_cnt = 0; adv = -1;
    for (int c = 0; c < 3000; c++) begin
      nxt;
      if (adv >= 0) words[adv] = 20'($urandom);
      adv = -1;
      reset = $urandom_range(0, 99) == 0;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) req[i] = $urandom_range(0, 7) != 0;
        else begin
          words[i] = 20'($urandom);
          req[i] = $urandom_range(0, 2) == 0;
        end
      end
      fifo_full = $urandom_range(0, 3) == 0;
      if (reset) begin m_own = -1; m_ptr = 0; m_cnt = 0; end
      smp;
      e_bz = m_own >= 0;
      e_g = 0; e_wr = 0; e_d = 0;
      if (e_bz) begin
        e_g = 4'(1) << m_own;
        e_wr = req[m_own] && !fifo_full;
        e_d = words[m_own];
      end
      chk("rnd_gnt", 32'(gnt), 32'(e_g));
      chk("rnd_write", 32'(fifo_write), 32'(e_wr));
      chk("rnd_busy", 32'(busy), 32'(e_bz));
      chk("rnd_owner", 32'(owner), e_bz ? m_own : 0);
      chk("rnd_data", 32'(fifo_data_in), 32'(e_d));
      if (!reset) begin
        if (e_wr) adv = m_own;
        if (m_own < 0) begin
          m_own = pick(req, m_ptr);
          m_cnt = 0;
        end else if ((e_wr && m_cnt == 3) || !req[m_own]) begin
          m_ptr = (m_own + 1) % 4;
          m_own = pick(req, m_ptr);
          m_cnt = 0;
        end else if (e_wr) m_cnt++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
